// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks (write and read side).
// Functions work on a 32-bit container; narrower pointers are zero-extended and truncated back.
package async_fifo_pkg;

  localparam int unsigned MaxPtrW = 32;

  typedef logic [MaxPtrW-1:0] ptr_t;

  // Pointer width carries one extra wrap bit above the address.
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended upper bits decode to zero, so this is width-agnostic.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[MaxPtrW-1] = gray[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_reg.sv
// Binary + Gray pointer register with enable; shared by write and read pointer blocks.
// Gray copy is registered separately so the cross-domain output is glitch-free.
module gray_ptr_reg
  import async_fifo_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-2:0] addr_o,
  output logic [W-1:0] gray_o,
  output logic [W-1:0] bin_next_o,
  output logic [W-1:0] gray_next_o
);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;

  always_comb begin
    bin_d  = bin_q + W'(en_i);
    gray_d = W'(bin2gray(ptr_t'(bin_d)));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign addr_o      = bin_q[W-2:0];
  assign gray_o      = gray_q;
  assign bin_next_o  = bin_d;
  assign gray_next_o = gray_d;

endmodule

// File: rtl/async_fifo_wptr.sv
// Write-side pointer, registered full flag and sticky overflow for the async FIFO.
// Define ASYNC_FIFO_WPTR_AFULL_EN to build the almost-full flag; otherwise afull_o is tied low.
module async_fifo_wptr
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic [ADDR_W:0]   rptr_gray_sync_i,
  output logic              wen_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W:0]   wptr_gray_o,
  output logic              full_o,
  output logic              afull_o,
  output logic              overflow_o
);

  localparam int unsigned PtrW = ptr_width(ADDR_W);

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  localparam logic [PtrW-1:0] FullMask = {2'b11, {(ADDR_W - 1){1'b0}}};

  logic            wen;
  logic [PtrW-1:0] wbin_next;
  logic [PtrW-1:0] wgray_next;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;

  assign wen = inc_i & ~full_q;

  gray_ptr_reg #(
    .W (PtrW)
  ) u_wptr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (wen),
    .addr_o      (waddr_o),
    .gray_o      (wptr_gray_o),
    .bin_next_o  (wbin_next),
    .gray_next_o (wgray_next)
  );

  always_comb begin
    full_d     = (wgray_next == (rptr_gray_sync_i ^ FullMask));
    overflow_d = overflow_q | (inc_i & full_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign wen_o      = wen;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

`ifdef ASYNC_FIFO_WPTR_AFULL_EN
  localparam logic [PtrW-1:0] AfullLevel = PtrW'((2 ** ADDR_W) - AFULL_THRESH);

  logic [PtrW-1:0] rbin_sync;
  logic [PtrW-1:0] used_next;
  logic            afull_q, afull_d;

  always_comb begin
    rbin_sync = PtrW'(gray2bin(ptr_t'(rptr_gray_sync_i)));
    used_next = wbin_next - rbin_sync;
    afull_d   = (used_next >= AfullLevel) | full_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign afull_o = afull_q;
`else
  logic unused_afull_cfg;
  assign unused_afull_cfg = ^{wbin_next, AFULL_THRESH[0]};
  assign afull_o = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wptr.sv
// Scoreboard bench for async_fifo_wptr: occupancy-count reference model feeds an expectation queue,
// a negedge monitor pops and compares every cycle.
module tb_async_fifo_wptr;

  localparam int unsigned AW    = 4;
  localparam int unsigned TH    = 2;
  localparam int          DEPTH = 16;
  localparam int unsigned PW    = AW + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          inc_i = 1'b0;
  logic [PW-1:0] rptr_gray_sync_i = '0;
  logic          wen_o;
  logic [AW-1:0] waddr_o;
  logic [PW-1:0] wptr_gray_o;
  logic          full_o;
  logic          afull_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  async_fifo_wptr #(
    .ADDR_W       (AW),
    .AFULL_THRESH (TH)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .inc_i            (inc_i),
    .rptr_gray_sync_i (rptr_gray_sync_i),
    .wen_o            (wen_o),
    .waddr_o          (waddr_o),
    .wptr_gray_o      (wptr_gray_o),
    .full_o           (full_o),
    .afull_o          (afull_o),
    .overflow_o       (overflow_o)
  );

  typedef struct {
    int wen;
    int waddr;
    int gray;
    int full;
    int afull;
    int ovf;
    bit in_rst;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: total writes and total reads as unbounded counts.
  int m_w   = 0;
  int rb    = 0;
  bit m_full  = 1'b0;
  bit m_afull = 1'b0;
  bit m_ovf   = 1'b0;

  function automatic int to_gray(input int b);
    int m;
    m = b % 32;
    return m ^ (m >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic step(input bit inc, input bit rst_mid);
    exp_t e;
    int   wnext;
    int   used;
    @(posedge clk);
    #1;
    inc_i = inc;
    rptr_gray_sync_i = PW'(to_gray(rb));
    if (rst_mid) begin
      #1;
      rst_i = 1'b1;
      m_w = 0; rb = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      rptr_gray_sync_i = '0;
    end else begin
      rst_i = 1'b0;
    end
    e.wen    = (inc && !m_full) ? 1 : 0;
    e.waddr  = m_w % DEPTH;
    e.gray   = to_gray(m_w);
    e.full   = m_full;
    e.afull  = m_afull;
    e.ovf    = m_ovf;
    e.in_rst = rst_mid;
    q.push_back(e);
    if (!rst_mid) begin
      wnext = m_w + e.wen;
      used  = wnext - rb;
      if (inc && m_full) m_ovf = 1'b1;
      m_full = (used == DEPTH);
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
      m_afull = (used >= DEPTH - TH) || m_full;
`else
      m_afull = 1'b0;
`endif
      m_w = wnext;
    end
  endtask

  // Monitor
  initial begin
    exp_t          e;
    logic [PW-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wen_o", int'(wen_o), e.wen);
        chk("waddr_o", int'(waddr_o), e.waddr);
        chk("wptr_gray_o", int'(wptr_gray_o), e.gray);
        chk("full_o", int'(full_o), e.full);
        chk("afull_o", int'(afull_o), e.afull);
        chk("overflow_o", int'(overflow_o), e.ovf);
        if (!e.in_rst) chk("gray_one_bit_step", ($countones(wptr_gray_o ^ prev) <= 1) ? 1 : 0, 1);
        prev = wptr_gray_o;
      end
    end
  end

  // Stimulus
  initial begin
    repeat (3) step(1'b0, 1'b0);

    // Fill to full with read pointer parked at 0, then overflow attempt.
    rb = 0;
    repeat (16) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Release by one read, then the next write lands at address 0.
    rb = 1;
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Wrap past binary 31 -> 0 with the reader 4 behind.
    repeat (40) begin
      if (m_w - 4 > rb) rb = m_w - 4;
      step(1'b1, 1'b0);
    end

    // Reset mid-burst, then almost-full sequence.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    repeat (14) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0);

    // Random producer/consumer traffic.
    repeat (400) begin
      if (rb < m_w && $urandom_range(0, 1) == 1) rb++;
      step($urandom_range(0, 3) != 0, 1'b0);
    end
    step(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
